// File: rtl/fir_pkg.sv
// Shared definitions for the FIR stage and its coefficient loader.
package fir_pkg;

    localparam int unsigned FIR_NUM_TAPS = 10;
    localparam int unsigned FIR_WIDTH    = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        PEND
    } loader_state_t;

    // Index width for a tap bank; never narrower than one bit.
    function automatic int unsigned tap_idx_width(input int unsigned num_taps);
        return (num_taps > 1) ? $clog2(num_taps) : 1;
    endfunction

endpackage

// File: rtl/fir_tap_bank.sv
// Double-buffered coefficient storage: shadow bank written word by word,
// copied whole into the active bank on swap.
module fir_tap_bank
    import fir_pkg::*;
#(
    parameter int unsigned NUM_TAPS = FIR_NUM_TAPS,
    parameter int unsigned WIDTH    = FIR_WIDTH,
    parameter int unsigned IDX_W    = tap_idx_width(NUM_TAPS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             swap,
    output logic [WIDTH-1:0] active [NUM_TAPS-1:0]
);

    logic [WIDTH-1:0] shadow [NUM_TAPS-1:0];

    // Decoded per-entry write keeps out-of-range indices from touching anything.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    shadow[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                active[i] <= '0;
            end
        end else if (swap) begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                active[i] <= shadow[i];
            end
        end
    end

endmodule

// File: rtl/fir_tap_loader.sv
// Streams a coefficient set into the shadow bank and swaps it into the
// active bank on the next sample boundary, so the filter never sees a mixed set.
module fir_tap_loader
    import fir_pkg::*;
#(
    parameter int unsigned NUM_TAPS = FIR_NUM_TAPS,
    parameter int unsigned WIDTH    = FIR_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             sample_strobe,
    output logic [WIDTH-1:0] taps [NUM_TAPS-1:0],
    output logic             tap_update,
    output logic             load_err,
    output logic             busy
);

    localparam int unsigned      IDX_W    = tap_idx_width(NUM_TAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

    loader_state_t    state;
    loader_state_t    state_next;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             at_last;
    logic             wr_en;
    logic             swap;
    logic             err_set;

    assign accept  = in_valid && in_ready;
    assign at_last = (idx == LAST_IDX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !in_last) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (in_last) begin
                        state_next = at_last ? PEND : IDLE;
                    end else if (at_last) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && in_last) begin
                    state_next = IDLE;
                end
            end
            PEND: begin
                if (sample_strobe) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A set is malformed when in_last does not coincide with the final index;
    // a single-word set in IDLE is the degenerate short case.
    always_comb begin
        in_ready = (state != PEND);
        busy     = (state != IDLE);
        wr_en    = accept && ((state == IDLE) || (state == LOAD));
        swap     = (state == PEND) && sample_strobe;
        err_set  = 1'b0;
        if (accept) begin
            if (state == IDLE) begin
                err_set = in_last;
            end else if (state == LOAD) begin
                err_set = (in_last != at_last);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (swap) begin
            idx <= '0;
        end else if (accept) begin
            case (state)
                IDLE:    idx <= in_last ? '0 : IDX_W'(1);
                LOAD:    idx <= (in_last || at_last) ? '0 : idx + IDX_W'(1);
                default: idx <= '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_err   <= 1'b0;
            tap_update <= 1'b0;
        end else begin
            tap_update <= swap;
            if (swap) begin
                load_err <= 1'b0;
            end else if (err_set) begin
                load_err <= 1'b1;
            end
        end
    end

    fir_tap_bank #(
        .NUM_TAPS (NUM_TAPS),
        .WIDTH    (WIDTH),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_data (in_data),
        .swap    (swap),
        .active  (taps)
    );

endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed bench for fir_tap_loader: load, swap, malformed sets, coincident strobe, reset.
module tb_fir_tap_loader;

    localparam int unsigned NT = 10;
    localparam int unsigned W  = 16;

    logic         clock;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic         sample_strobe;
    logic [W-1:0] taps [NT-1:0];
    logic         tap_update;
    logic         load_err;
    logic         busy;

    logic [W-1:0] exp_taps [NT-1:0];
    int unsigned  n_checks;
    int unsigned  n_passed;

    fir_tap_loader #(
        .NUM_TAPS (NT),
        .WIDTH    (W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .sample_strobe (sample_strobe),
        .taps          (taps),
        .tap_update    (tap_update),
        .load_err      (load_err),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_exp(input int unsigned base);
        for (int i = 0; i < NT; i++) exp_taps[i] = W'(base + i);
    endtask

    task automatic check_taps(input string tag);
        for (int i = 0; i < NT; i++) begin
            check($sformatf("%s taps[%0d]", tag, i), 32'(taps[i]), 32'(exp_taps[i]));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Send n consecutive words base..base+n-1, in_last on word last_at (1-based).
    task automatic send_words(input int unsigned base, input int unsigned n, input int unsigned last_at,
                              input string tag);
        for (int i = 1; i <= n; i++) begin
            in_valid = 1'b1;
            in_data  = W'(base + i - 1);
            in_last  = (i == last_at);
            check($sformatf("%s ready w%0d", tag, i), 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic strobe();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_passed      = 0;
        reset         = 1'b0;
        in_data       = '0;
        in_valid      = 1'b0;
        in_last       = 1'b0;
        sample_strobe = 1'b0;
        set_exp(0);
        for (int i = 0; i < NT; i++) exp_taps[i] = '0;

        // Reset state
        #12;
        check_taps("rst");
        check("rst ready", 32'(in_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst upd", 32'(tap_update), 32'd0);
        check("rst err", 32'(load_err), 32'd0);
        reset = 1'b1;
        tick();

        // 1: words 1..10, valid held, strobe 5 cycles later
        send_words(1, NT, NT, "t1");
        check("t1 busy", 32'(busy), 32'd1);
        check("t1 pend ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            check("t1 wait upd", 32'(tap_update), 32'd0);
            check("t1 wait tap0", 32'(taps[0]), 32'd0);
            tick();
        end
        strobe();
        set_exp(1);
        check_taps("t1 swap");
        check("t1 upd", 32'(tap_update), 32'd1);
        tick();
        check("t1 upd once", 32'(tap_update), 32'd0);
        check("t1 idle", 32'(busy), 32'd0);

        // 2: set A, swap; set B with a gap
        send_words(16'h100, NT, NT, "t2a");
        strobe();
        set_exp(16'h100);
        check_taps("t2 A");
        send_words(16'h200, 5, 0, "t2b1");
        for (int c = 0; c < 3; c++) tick();
        send_words(16'h205, 5, 5, "t2b2");
        check_taps("t2 pend A");
        check("t2 pend ready", 32'(in_ready), 32'd0);
        tick();
        check("t2 pend ready2", 32'(in_ready), 32'd0);
        strobe();
        set_exp(16'h200);
        check_taps("t2 B");

        // 3: short set, then good set
        send_words(16'h300, 4, 4, "t3s");
        check("t3 err", 32'(load_err), 32'd1);
        check("t3 idle", 32'(busy), 32'd0);
        check("t3 ready", 32'(in_ready), 32'd1);
        check_taps("t3 unchanged");
        send_words(16'h400, NT, NT, "t3g");
        check("t3 err sticky", 32'(load_err), 32'd1);
        strobe();
        set_exp(16'h400);
        check_taps("t3 good");
        check("t3 err clr", 32'(load_err), 32'd0);

        // 4: long set of 13 words
        send_words(16'h500, NT, 0, "t4a");
        check("t4 err at 10", 32'(load_err), 32'd1);
        check("t4 drain busy", 32'(busy), 32'd1);
        send_words(16'h50A, 3, 3, "t4b");
        check("t4 idle", 32'(busy), 32'd0);
        check("t4 err", 32'(load_err), 32'd1);
        check_taps("t4 unchanged");
        strobe();
        check("t4 idle strobe upd", 32'(tap_update), 32'd0);
        check_taps("t4 idle strobe");

        // 5: final word coincident with strobe
        send_words(16'h600, NT - 1, 0, "t5a");
        in_valid      = 1'b1;
        in_data       = W'(16'h609);
        in_last       = 1'b1;
        sample_strobe = 1'b1;
        tick();
        in_valid      = 1'b0;
        in_last       = 1'b0;
        sample_strobe = 1'b0;
        check("t5 no upd", 32'(tap_update), 32'd0);
        check("t5 pend", 32'(in_ready), 32'd0);
        check_taps("t5 no swap");
        tick();
        check("t5 still pend", 32'(busy), 32'd1);
        strobe();
        set_exp(16'h600);
        check_taps("t5 swap");
        check("t5 upd", 32'(tap_update), 32'd1);

        // 6: reset during LOAD (idx=6), then during PEND
        send_words(16'h700, 6, 0, "t6a");
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < NT; i++) exp_taps[i] = '0;
        check_taps("t6 rst load");
        check("t6 rst busy", 32'(busy), 32'd0);
        #3 reset = 1'b1;
        tick();
        check("t6 ready", 32'(in_ready), 32'd1);
        send_words(16'h700, NT, NT, "t6b");
        strobe();
        set_exp(16'h700);
        check_taps("t6 fresh");
        send_words(16'h800, NT, NT, "t6c");
        check("t6 pend", 32'(in_ready), 32'd0);
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < NT; i++) exp_taps[i] = '0;
        check_taps("t6 rst pend");
        check("t6 rst ready", 32'(in_ready), 32'd1);
        #3 reset = 1'b1;
        tick();
        strobe();
        check("t6 lost upd", 32'(tap_update), 32'd0);
        send_words(16'h900, NT, NT, "t6d");
        strobe();
        set_exp(16'h900);
        check_taps("t6 final");
        check("t6 err", 32'(load_err), 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
